// File: rtl/ad9914_spi_responder_if.sv
// Request/busy handshake between the workflow controller and one AD9914
// responder.
//   update        : full-configuration request (level)
//   update_config : rising-step-only request (level)
//   sweep         : sweep-start request (level)
//   sweep_step    : rising step word, latched by the responder on accept
//   busy          : responder is serving a request
// master = workflow controller, slave = ad9914_spi_responder.
interface ad9914_spi_responder_if;
  logic        update;
  logic        update_config;
  logic        sweep;
  logic [31:0] sweep_step;
  logic        busy;

  modport master (output update, update_config, sweep, sweep_step, input busy);
  modport slave  (input update, update_config, sweep, sweep_step, output busy);
endinterface

// File: rtl/ad9914_spi_responder.sv
// AD9914 serial-port responder. Serves full-update, step-update and
// sweep-start requests by writing 40-bit register frames (write bit,
// 7-bit address, 32-bit data, MSB first), pulsing IO_UPDATE, or restarting
// the digital ramp through DRCTL.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   bus (slave)   : update / update_config / sweep / sweep_step / busy
//   dds_cs_n, dds_sclk, dds_sdio : serial write port (sclk idles low)
//   dds_sdo       : serial readback data
//   dds_io_update : IO_UPDATE strobe
//   dds_drctl     : digital ramp control
//   cfg_err       : sticky readback-mismatch flag
// Build option: define AD9914_READBACK_EN to read 0x06 back after an
// update_config write and compare it with the latched step word.
module ad9914_spi_responder #(
  parameter int          SCLK_DIV         = 4,
  parameter int          IOUP_CYCLES      = 4,
  parameter int          DRCTL_LOW_CYCLES = 8,
  parameter logic [31:0] CFR1_VAL         = 32'h00010000,
  parameter logic [31:0] CFR2_VAL         = 32'h00080000,
  parameter logic [31:0] LOWER_FTW        = 32'h1999999A,
  parameter logic [31:0] UPPER_FTW        = 32'h26666666,
  parameter logic [31:0] FALL_STEP        = 32'hFFFFFFFF,
  parameter logic [31:0] RAMP_RATE        = 32'h00010001
) (
  input  logic                  clk,
  input  logic                  rst,
  ad9914_spi_responder_if.slave bus,
  output logic                  dds_cs_n,
  output logic                  dds_sclk,
  output logic                  dds_sdio,
  input  logic                  dds_sdo,
  output logic                  dds_io_update,
  output logic                  dds_drctl,
  output logic                  cfg_err
);
`ifdef AD9914_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  localparam logic [15:0] DIV    = 16'(SCLK_DIV);
  localparam logic [15:0] DIV_M1 = 16'(SCLK_DIV - 1);
  localparam logic [15:0] BIT_M1 = 16'(2 * SCLK_DIV - 1);
  localparam logic [15:0] IOU_M1 = 16'(IOUP_CYCLES - 1);
  localparam logic [15:0] DRL_M1 = 16'(DRCTL_LOW_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, IOUP, DR_LOW, DONE} state_t;
  typedef enum logic [1:0] {M_FULL, M_CFG, M_SWEEP} mode_t;

  // {address, data} for write-list position idx; update_config uses idx 4 only
  function automatic logic [38:0] frame_word(input logic [2:0] idx, input logic [31:0] step);
    case (idx)
      3'd0:    frame_word = {7'h00, CFR1_VAL};
      3'd1:    frame_word = {7'h01, CFR2_VAL};
      3'd2:    frame_word = {7'h04, LOWER_FTW};
      3'd3:    frame_word = {7'h05, UPPER_FTW};
      3'd4:    frame_word = {7'h06, step};
      3'd5:    frame_word = {7'h07, FALL_STEP};
      default: frame_word = {7'h08, RAMP_RATE};
    endcase
  endfunction

  state_t      state, state_d;
  mode_t       mode, mode_d;
  logic [15:0] cnt, cnt_d;
  logic [5:0]  bit_cnt, bit_d;
  logic [2:0]  fidx, fidx_d;
  logic [39:0] sh, sh_d;
  logic [31:0] rd_sh, rd_d;
  logic        rd_phase, rdp_d;
  logic [31:0] step_q, step_d;
  logic [2:0]  arm, arm_d;
  logic [2:0]  req_v;
  logic        drctl_q, drctl_d, err_q, err_d;
  logic        busy_q, cs_n_q, sclk_q, sdio_q, iou_q;

  assign req_v = {bus.sweep, bus.update_config, bus.update};

  always_comb begin
    state_d = state;
    mode_d  = mode;
    cnt_d   = cnt;
    bit_d   = bit_cnt;
    fidx_d  = fidx;
    sh_d    = sh;
    rd_d    = rd_sh;
    rdp_d   = rd_phase;
    step_d  = step_q;
    drctl_d = drctl_q;
    err_d   = err_q;
    // a request re-arms only once its level has been seen low
    arm_d   = arm | ~req_v;
    case (state)
      IDLE: begin
        cnt_d = '0;
        rdp_d = 1'b0;
        if (req_v[0] && arm[0]) begin
          mode_d = M_FULL; fidx_d = 3'd0; step_d = bus.sweep_step;
          arm_d[0] = 1'b0; state_d = LOAD;
        end else if (req_v[1] && arm[1]) begin
          mode_d = M_CFG; fidx_d = 3'd4; step_d = bus.sweep_step;
          arm_d[1] = 1'b0; state_d = LOAD;
        end else if (req_v[2] && arm[2]) begin
          mode_d = M_SWEEP; drctl_d = 1'b0;
          arm_d[2] = 1'b0; state_d = DR_LOW;
        end
      end
      LOAD: begin
        sh_d    = rd_phase ? {1'b1, 7'h06, 32'h0} : {1'b0, frame_word(fidx, step_q)};
        cnt_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // readback data follows the 8 instruction bits; take it as sclk rises
        if (RB_EN && rd_phase && cnt == DIV_M1 && bit_cnt >= 6'd8)
          rd_d = {rd_sh[30:0], dds_sdo};
        if (cnt == BIT_M1) begin
          cnt_d = '0;
          sh_d  = {sh[38:0], 1'b0};
          bit_d = bit_cnt + 6'd1;
          if (bit_cnt == 6'd39) state_d = GAP;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      GAP: begin
        if (cnt == DIV_M1) begin
          cnt_d = '0;
          if (mode == M_FULL && fidx != 3'd6) begin
            fidx_d = fidx + 3'd1; state_d = LOAD;
          end else if (RB_EN && mode == M_CFG && !rd_phase) begin
            rdp_d = 1'b1; state_d = LOAD;
          end else begin
            if (rd_phase && rd_sh != step_q) err_d = 1'b1;
            state_d = IOUP;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      IOUP: begin
        if (cnt == IOU_M1) state_d = DONE;
        else               cnt_d = cnt + 16'd1;
      end
      DR_LOW: begin
        if (cnt == DRL_M1) begin drctl_d = 1'b1; state_d = DONE; end
        else               cnt_d = cnt + 16'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mode     <= M_FULL;
      cnt      <= '0;
      bit_cnt  <= '0;
      fidx     <= '0;
      sh       <= '0;
      rd_sh    <= '0;
      rd_phase <= 1'b0;
      step_q   <= '0;
      arm      <= 3'b111;
      drctl_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      sdio_q   <= 1'b0;
      iou_q    <= 1'b0;
    end else begin
      state    <= state_d;
      mode     <= mode_d;
      cnt      <= cnt_d;
      bit_cnt  <= bit_d;
      fidx     <= fidx_d;
      sh       <= sh_d;
      rd_sh    <= rd_d;
      rd_phase <= rdp_d;
      step_q   <= step_d;
      arm      <= arm_d;
      drctl_q  <= drctl_d;
      err_q    <= err_d;
      // pins registered from next-state values so they never glitch
      busy_q   <= (state_d != IDLE);
      cs_n_q   <= (state_d != SHIFT);
      sclk_q   <= (state_d == SHIFT) && (cnt_d >= DIV);
      sdio_q   <= (state_d == SHIFT) && sh_d[39];
      iou_q    <= (state_d == IOUP);
    end
  end

  assign bus.busy      = busy_q;
  assign dds_cs_n      = cs_n_q;
  assign dds_sclk      = sclk_q;
  assign dds_sdio      = sdio_q;
  assign dds_io_update = iou_q;
  assign dds_drctl     = drctl_q;
  assign cfg_err       = err_q;
endmodule

// File: tb/tb_ad9914_spi_responder.sv
// Directed bench for ad9914_spi_responder: a negedge monitor decodes serial
// frames and pops expected {rw, addr, data} words from a scoreboard queue,
// and measures io_update / drctl / busy widths.
module tb_ad9914_spi_responder;
`ifdef AD9914_READBACK_EN
  localparam int NFR = 2;
  localparam int CFG_LEN = 655;
`else
  localparam int NFR = 1;
  localparam int CFG_LEN = 330;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dds_cs_n, dds_sclk, dds_sdio, dds_io_update, dds_drctl, cfg_err;
  logic dds_sdo = 1'b0;

  ad9914_spi_responder_if bus();

  ad9914_spi_responder dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dds_cs_n(dds_cs_n), .dds_sclk(dds_sclk), .dds_sdio(dds_sdio), .dds_sdo(dds_sdo),
    .dds_io_update(dds_io_update), .dds_drctl(dds_drctl), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [39:0] exp_q[$];
  logic [39:0] cap = '0;
  logic [31:0] sdo_val = '0;
  int nframes = 0, nstarts = 0, nbits = 0;
  int iou_pulses = 0, iou_w = 0, drl_w = 0, drl_last = 0, bcnt = 0, blen = 0;
  longint cyc = 0, t_iou_fall = 0, t_dr_fall = 0;
  logic sclk_p = 1'b0, cs_p = 1'b1, iou_p = 1'b0, dr_p = 1'b0, busy_p = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int maxc, input string tag);
    int n = 0;
    while (bus.busy !== lvl && n < maxc) begin @(negedge clk); n++; end
    chk(tag, bus.busy, lvl);
  endtask

  task automatic push_cfg(input logic [31:0] step);
    exp_q.push_back({1'b0, 7'h06, step});
`ifdef AD9914_READBACK_EN
    exp_q.push_back({1'b1, 7'h06, 32'h0});
`endif
  endtask

  task automatic push_full(input logic [31:0] step);
    exp_q.push_back({1'b0, 7'h00, 32'h00010000});
    exp_q.push_back({1'b0, 7'h01, 32'h00080000});
    exp_q.push_back({1'b0, 7'h04, 32'h1999999A});
    exp_q.push_back({1'b0, 7'h05, 32'h26666666});
    exp_q.push_back({1'b0, 7'h06, step});
    exp_q.push_back({1'b0, 7'h07, 32'hFFFFFFFF});
    exp_q.push_back({1'b0, 7'h08, 32'h00010001});
  endtask

  // one update_config transaction with the given step and readback data
  task automatic cfg_once(input logic [31:0] step, input logic [31:0] sdo, input string tag);
    int f0 = nframes;
    int i0 = iou_pulses;
    bus.sweep_step = step;
    sdo_val = sdo;
    push_cfg(step);
    bus.update_config = 1'b1;
    wait_busy(1'b1, 10, {tag, "_rise"});
    bus.update_config = 1'b0;
    wait_busy(1'b0, 2000, {tag, "_fall"});
    @(negedge clk);
    chk({tag, "_frames"}, nframes - f0, NFR);
    chk({tag, "_iou"}, iou_pulses - i0, 1);
    chk({tag, "_busylen"}, blen, CFG_LEN);
    chk({tag, "_queue"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      nbits = 0; sclk_p = 1'b0; cs_p = 1'b1; iou_p = 1'b0; iou_w = 0;
      busy_p = 1'b0; bcnt = 0; dds_sdo = 1'b0; dr_p = 1'b0;
    end else begin
      if (cs_p && !dds_cs_n) begin nbits = 0; nstarts++; end
      if (!dds_cs_n && dds_sclk && !sclk_p) begin cap = {cap[38:0], dds_sdio}; nbits++; end
      // model the DDS driving readback bits on sclk falling edges
      if (!dds_cs_n && !dds_sclk && sclk_p)
        dds_sdo = (nbits >= 8 && nbits < 40) ? sdo_val[39 - nbits] : 1'b0;
      if (!cs_p && dds_cs_n) begin
        nframes++;
        chk("frame_bits", nbits, 40);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL frame_unexpected observed=%0h expected=none", cap);
        end
        if (exp_q.size() != 0) chk("frame", cap, exp_q.pop_front());
      end
      if (dds_io_update) iou_w++;
      if (iou_p && !dds_io_update) begin
        iou_pulses++;
        chk("iou_width", iou_w, 4);
        iou_w = 0;
        t_iou_fall = cyc;
      end
      if (dr_p && !dds_drctl) begin drl_w = 0; t_dr_fall = cyc; end
      if (!dds_drctl) drl_w++;
      if (!dr_p && dds_drctl) drl_last = drl_w;
      if (bus.busy) bcnt++;
      if (busy_p && !bus.busy) begin blen = bcnt; bcnt = 0; end
      sclk_p = dds_sclk; cs_p = dds_cs_n; iou_p = dds_io_update; busy_p = bus.busy;
    end
    dr_p = dds_drctl;
  end

  initial begin
    int f0, i0, s0, n;
    bus.update = 1'b0; bus.update_config = 1'b0; bus.sweep = 1'b0; bus.sweep_step = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cs_n", dds_cs_n, 1);
    chk("rst_sclk", dds_sclk, 0);
    chk("rst_sdio", dds_sdio, 0);
    chk("rst_iou", dds_io_update, 0);
    chk("rst_drctl", dds_drctl, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // full update: seven frames in order, one io_update
    f0 = nframes; i0 = iou_pulses;
    bus.sweep_step = 32'h00221B26;
    push_full(32'h00221B26);
    bus.update = 1'b1;
    wait_busy(1'b1, 10, "upd_rise");
    bus.update = 1'b0;
    wait_busy(1'b0, 3000, "upd_fall");
    @(negedge clk);
    chk("upd_frames", nframes - f0, 7);
    chk("upd_iou", iou_pulses - i0, 1);
    chk("upd_queue", exp_q.size(), 0);

    // update_config held for 1000 cycles triggers once; late step change ignored
    f0 = nframes; i0 = iou_pulses;
    bus.sweep_step = 32'h0006D23A;
    sdo_val = 32'h0006D23A;
    push_cfg(32'h0006D23A);
    bus.update_config = 1'b1;
    wait_busy(1'b1, 10, "held_rise");
    bus.sweep_step = 32'hDEADBEEF;
    repeat (995) @(negedge clk);
    chk("held_busy", bus.busy, 0);
    chk("held_frames", nframes - f0, NFR);
    chk("held_iou", iou_pulses - i0, 1);
    chk("held_busylen", blen, CFG_LEN);
    chk("held_queue", exp_q.size(), 0);
    chk("held_cfg_err", cfg_err, 0);
    bus.update_config = 1'b0;
    @(negedge clk);
    cfg_once(32'hDEADBEEF, 32'hDEADBEEF, "rearm");

    // sweep pulses: first raises drctl from reset, second shows the low window
    s0 = nstarts;
    bus.sweep = 1'b1; @(negedge clk); bus.sweep = 1'b0;
    wait_busy(1'b0, 50, "sw1_fall");
    @(negedge clk);
    chk("sw1_drctl", dds_drctl, 1);
    chk("sw1_busylen", blen, 9);
    bus.sweep = 1'b1; @(negedge clk); bus.sweep = 1'b0;
    wait_busy(1'b0, 50, "sw2_fall");
    @(negedge clk);
    chk("sw2_low_width", drl_last, 8);
    chk("sw2_drctl", dds_drctl, 1);
    chk("sw_no_cs", nstarts - s0, 0);

    // update and sweep together: update first, then the sweep restart
    push_full(32'h00221B26);
    bus.sweep_step = 32'h00221B26;
    bus.update = 1'b1; bus.sweep = 1'b1;
    wait_busy(1'b1, 10, "both_rise");
    bus.update = 1'b0;
    wait_busy(1'b0, 3000, "both_upd_fall");
    wait_busy(1'b1, 10, "both_sw_rise");
    bus.sweep = 1'b0;
    wait_busy(1'b0, 50, "both_sw_fall");
    @(negedge clk);
    chk("both_order", t_dr_fall > t_iou_fall, 1);
    chk("both_low_width", drl_last, 8);
    chk("both_drctl", dds_drctl, 1);
    chk("both_queue", exp_q.size(), 0);

    // reset during bit 20 aborts the frame without io_update
    i0 = iou_pulses;
    bus.sweep_step = 32'h12345678;
    bus.update_config = 1'b1;
    wait_busy(1'b1, 10, "abort_rise");
    bus.update_config = 1'b0;
    n = 0;
    while (nbits != 20 && n < 400) begin @(negedge clk); n++; end
    chk("abort_bit20", nbits, 20);
    #2 rst = 1'b0;
    #1;
    chk("abort_cs_n", dds_cs_n, 1);
    chk("abort_sclk", dds_sclk, 0);
    chk("abort_busy", bus.busy, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_iou", iou_pulses - i0, 0);
    rst = 1'b1;
    @(negedge clk);
    cfg_once(32'h0006D23A, 32'h0006D23A, "post_rst");
    chk("post_rst_cfg_err", cfg_err, 0);

    // readback mismatch: flagged only when readback is built in
    cfg_once(32'h0006D23A, 32'h0006D23B, "rb_bad");
`ifdef AD9914_READBACK_EN
    chk("rb_bad_cfg_err", cfg_err, 1);
`else
    chk("rb_bad_cfg_err", cfg_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ad9914_spi_responder.md
Name: ad9914_spi_responder

Overview:
- Responder side of the workflow-to-DDS request/busy handshake. Accepts full-update, step-update and sweep-start requests and asserts busy while serving them.
- Turns each request into AD9914 serial-port register writes, an IO_UPDATE pulse or a DRCTL restart.
- Sits between the workflow controller and the AD9914 pins; one instance per DDS.

Parameters:
- SCLK_DIV, 4, clk cycles per SCLK half-period (>=2)
- IOUP_CYCLES, 4, IO_UPDATE high width in clk cycles
- DRCTL_LOW_CYCLES, 8, DRCTL low time before re-raise on sweep start
- CFR1_VAL, 32'h00010000, CFR1 contents written on full update
- CFR2_VAL, 32'h00080000, CFR2 contents (digital ramp enable, no-dwell high)
- LOWER_FTW, 32'h1999999A, ramp lower limit
- UPPER_FTW, 32'h26666666, ramp upper limit
- FALL_STEP, 32'hFFFFFFFF, falling step (fast return)
- RAMP_RATE, 32'h00010001, rising/falling ramp rate word

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- update  in  1  full-configuration request (level, held until busy seen)
- update_config  in  1  rising-step-only request (level)
- sweep  in  1  sweep-start request (level)
- sweep_step  in  32  rising step word, latched at request accept
- busy  out  1  high while a request is being served
- dds_cs_n  out  1  serial chip select
- dds_sclk  out  1  serial clock, idle low
- dds_sdio  out  1  serial data, MSB first
- dds_sdo  in  1  serial readback data (used only with optional feature)
- dds_io_update  out  1  IO_UPDATE strobe
- dds_drctl  out  1  digital ramp control
- cfg_err  out  1  readback mismatch flag

Behaviour:
- Reset (rst low, async): busy=0, dds_cs_n=1, dds_sclk=0, dds_sdio=0, dds_io_update=0, dds_drctl=0, cfg_err=0, FSM=IDLE, all arm bits set.
- A reset asserted mid-frame aborts the frame immediately; no IO_UPDATE is issued.
- Arming: each request input has an arm bit. A request is accepted only when its level is high and its arm bit is set; acceptance clears the arm bit. The arm bit is set again only after that input is sampled low. A held request therefore never triggers twice.
- Priority when several requests are high in the same IDLE cycle: update > update_config > sweep. Losers stay armed and are served later.
- busy rises the cycle after accept and falls the cycle the FSM re-enters IDLE. Requests arriving while busy wait until IDLE.
- FSM states: IDLE, LOAD, SHIFT, GAP, IOUP, DR_LOW, DONE.
- LOAD forms a 40-bit frame: bit 39 = 0 (write), bits 38:32 = address, bits 31:0 = data.
- SHIFT: cs_n low; sdio changes while sclk is low; each bit lasts 2*SCLK_DIV cycles; 40 bits per frame; sclk ends low.
- GAP: cs_n high for SCLK_DIV cycles, then next frame or IOUP.
- update write list, in order: CFR1 0x00, CFR2 0x01, lower 0x04, upper 0x05, rising step 0x06 (latched sweep_step), falling step 0x07, ramp rate 0x08. Then IOUP.
- update_config: single frame to 0x06 with latched sweep_step, then IOUP.
- IOUP: io_update high for IOUP_CYCLES, then DONE, then IDLE.
- sweep: no serial frames. DR_LOW drives drctl=0 for DRCTL_LOW_CYCLES, then drctl=1 and held high; then DONE, then IDLE.
- update_config busy length, SCLK_DIV=4, IOUP_CYCLES=4: 1 LOAD + 320 SHIFT + 4 GAP + 4 IOUP + 1 DONE = 330 cycles ±1.
- sweep_step changes after accept do not affect the frame in flight.

Optional Feature:
- Macro: AD9914_READBACK_EN.
- Defined: after the 0x06 write of update_config, before IOUP, issue a read frame (bit 39 = 1, addr 0x06). Shift in 32 bits from dds_sdo, sampled on sclk rising. If the result differs from the latched step, set cfg_err=1 (sticky until reset) and still pulse IOUP. Busy extends by one frame plus one gap.
- Not defined: no read frame, dds_sdo ignored, cfg_err held 0.

Test Plan:
- update with sweep_step=32'h00221B26 -> 7 frames, addresses 00,01,04,05,06,07,08 in order; frame 5 data 00221B26; one 4-cycle io_update; busy then falls.
- update_config held high 1000 cycles, sweep_step=32'h0006D23A -> exactly one frame to 0x06 with 0006D23A; busy ~330 cycles; no second frame until update_config drops and rises again.
- sweep pulse -> drctl low exactly 8 cycles then high; no cs_n activity; busy high about 10 cycles.
- update and sweep high in the same cycle -> full update served first, then the sweep restart; drctl ends high.
- rst low during bit 20 of a frame -> cs_n=1, sclk=0 in the same cycle; no io_update; after release a new update_config completes normally.
- AD9914_READBACK_EN defined, dds_sdo returns 0006D23B for expected 0006D23A -> cfg_err=1 and io_update still pulses; with matching data cfg_err stays 0.
